// File: rtl/leb128_fetch.sv
// LEB128 immediate fetcher: reads one byte per two cycles from genrom and returns
// the decoded (optionally sign-extended) value plus the address after the immediate.
module leb128_fetch #(
  parameter int MEM_ADDR  = 4,
  parameter int MEM_EXTRA = 4,
  parameter int USE_64B   = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [MEM_ADDR:0]             i_addr_in,
  input  logic                          i_is_signed,
  input  logic                          i_is64,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [63:0]                   o_value,
  output logic [MEM_ADDR:0]             o_next_addr,
  output logic [1:0]                    o_error,
  output logic [MEM_ADDR:0]             o_mem_addr,
  output logic [MEM_EXTRA-1:0]          o_mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   i_mem_data,
  input  logic                          i_mem_error
);
  typedef enum logic [1:0] {IDLE, FETCH, ACC} state_t;

  state_t            r_state;
  logic [MEM_ADDR:0] r_ptr, r_next_addr;
  logic              r_sgn, r_64;
  logic [63:0]       r_acc, r_value;
  logic [6:0]        r_shift;
  logic [3:0]        r_count;
  logic [1:0]        r_error;

  logic [7:0]        w_byte;
  logic              w_unused_data;
  logic [3:0]        w_count, w_max;
  logic [6:0]        w_shift, w_width;
  logic [5:0]        w_sidx;
  logic [63:0]       w_acc, w_ext, w_trunc, w_res;
  logic [MEM_ADDR:0] w_ptr;
  logic              w_last, w_bad, w_fin;
  logic [1:0]        w_err;

  assign w_byte        = i_mem_data[7:0];
  assign w_unused_data = ^i_mem_data[(2**MEM_EXTRA)*8-1:8];
  assign w_count       = r_count + 4'd1;
  assign w_shift       = r_shift + 7'd7;
  assign w_sidx        = 6'(w_shift - 7'd1);
  assign w_acc         = r_acc | (64'(w_byte[6:0]) << r_shift);
  assign w_ptr         = r_ptr + 1'b1;
  assign w_max         = r_64 ? 4'd10 : 4'd5;
  assign w_width       = r_64 ? 7'd64 : 7'd32;
  assign w_last        = (w_count == w_max);

  // Final byte of a max-length encoding only carries the low bits of the target width.
  always_comb begin
    w_bad = 1'b0;
    if (w_last) begin
      if (r_64) w_bad = r_sgn ? (w_byte[6:1] != {6{w_byte[0]}}) : (w_byte[6:1] != 6'd0);
      else      w_bad = r_sgn ? (w_byte[6:4] != {3{w_byte[3]}}) : (w_byte[6:4] != 3'd0);
    end
  end

  always_comb begin
    w_ext = w_acc;
    if (r_sgn && (w_shift < w_width) && w_acc[w_sidx])
      w_ext = w_acc | (~64'd0 << w_shift);
  end

  assign w_trunc = r_64 ? w_ext : {32'd0, w_ext[31:0]};

  always_comb begin
    w_err = 2'd0;
    if (i_mem_error)      w_err = 2'd1;
    else if (w_byte[7])   w_err = w_last ? 2'd2 : 2'd0;
    else if (w_bad)       w_err = 2'd3;
  end

  assign w_res = (w_err == 2'd0) ? w_trunc : 64'd0;
  assign w_fin = (r_state == ACC) && (i_mem_error || !w_byte[7] || w_last);

  // Results appear in the final ACC cycle and are then held from the registers.
  assign o_done      = w_fin;
  assign o_value     = w_fin ? w_res : r_value;
  assign o_next_addr = w_fin ? w_ptr : r_next_addr;
  assign o_error     = w_fin ? w_err : r_error;
  assign o_busy      = (r_state != IDLE);
  assign o_mem_addr  = o_busy ? r_ptr : '0;
  assign o_mem_extra = '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_sgn       <= 1'b0;
      r_64        <= 1'b0;
      r_acc       <= '0;
      r_shift     <= '0;
      r_count     <= '0;
      r_value     <= '0;
      r_next_addr <= '0;
      r_error     <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_ptr   <= i_addr_in;
          r_sgn   <= i_is_signed;
          r_64    <= (USE_64B != 0) && i_is64;
          r_acc   <= '0;
          r_shift <= '0;
          r_count <= '0;
          r_state <= FETCH;
        end
        FETCH: r_state <= ACC;
        ACC: begin
          r_count <= w_count;
          r_acc   <= w_acc;
          r_shift <= w_shift;
          r_ptr   <= w_ptr;
          if (w_fin) begin
            r_value     <= w_res;
            r_next_addr <= w_ptr;
            r_error     <= w_err;
            r_state     <= IDLE;
          end else begin
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_leb128_fetch.sv
// Directed bench for leb128_fetch: registered-ROM model, hand-computed expected values.
module tb_leb128_fetch;
  logic         clk = 1'b0;
  logic         reset, start, is_signed, is64;
  logic [4:0]   addr_in;
  logic         busy, done;
  logic [63:0]  value;
  logic [4:0]   next_addr, mem_addr;
  logic [1:0]   error;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data;
  logic         mem_error;

  logic [7:0]   rom [32];
  logic         rerr[32];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  leb128_fetch #(.MEM_ADDR(4), .MEM_EXTRA(4), .USE_64B(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_addr_in(addr_in),
    .i_is_signed(is_signed), .i_is64(is64), .o_busy(busy), .o_done(done),
    .o_value(value), .o_next_addr(next_addr), .o_error(error),
    .o_mem_addr(mem_addr), .o_mem_extra(mem_extra), .i_mem_data(mem_data),
    .i_mem_error(mem_error));

  // Upper data bits carry junk so only [7:0] may matter.
  always @(posedge clk) begin
    mem_data  <= {{15{8'hA5}}, rom[mem_addr]};
    mem_error <= rerr[mem_addr];
  end

  task automatic do_start(input logic [4:0] a, input logic s, input logic w);
    @(negedge clk);
    start = 1'b1; addr_in = a; is_signed = s; is64 = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc counts cycles since the cycle in which start was sampled.
  task automatic wait_done(input int maxc, output int cyc);
    cyc = 1;
    while (!done && cyc < maxc) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (value !== 64'd0) begin failures++; $display("FAIL reset_value got=%h exp=0", value); end
    checks++; if (next_addr !== 5'd0) begin failures++; $display("FAIL reset_next got=%h exp=0", next_addr); end
    checks++; if (error !== 2'd0) begin failures++; $display("FAIL reset_error got=%h exp=0", error); end
    checks++; if (mem_addr !== 5'd0 || mem_extra !== 4'd0)
      begin failures++; $display("FAIL reset_mem got=%h/%h exp=0/0", mem_addr, mem_extra); end
  endtask

  task automatic test_single;
    int cyc;
    rom[0] = 8'h2A;
    do_start(5'd0, 1'b0, 1'b0);
    wait_done(20, cyc);
    checks++; if (!done || cyc != 2) begin failures++; $display("FAIL single_lat got=%0d done=%b exp=2", cyc, done); end
    checks++; if (value !== 64'h2A) begin failures++; $display("FAIL single_value got=%h exp=2a", value); end
    checks++; if (next_addr !== 5'd1 || error !== 2'd0)
      begin failures++; $display("FAIL single_next got=%h/%h exp=1/0", next_addr, error); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_done got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL single_idle got=%b/%b exp=0/0", busy, done); end
    checks++; if (value !== 64'h2A || next_addr !== 5'd1)
      begin failures++; $display("FAIL single_hold got=%h/%h exp=2a/1", value, next_addr); end
  endtask

  task automatic test_multi;
    int cyc;
    rom[3] = 8'hE5; rom[4] = 8'h8E; rom[5] = 8'h26;
    do_start(5'd3, 1'b0, 1'b0);
    checks++; if (mem_addr !== 5'd3) begin failures++; $display("FAIL multi_memaddr got=%h exp=3", mem_addr); end
    wait_done(20, cyc);
    checks++; if (!done || cyc != 6) begin failures++; $display("FAIL multi_lat got=%0d done=%b exp=6", cyc, done); end
    checks++; if (value !== 64'h98765 || next_addr !== 5'd6 || error !== 2'd0)
      begin failures++; $display("FAIL multi_value got=%h/%h/%h exp=98765/6/0", value, next_addr, error); end
  endtask

  task automatic test_signed;
    int cyc;
    rom[0] = 8'h7E;
    do_start(5'd0, 1'b1, 1'b0);
    wait_done(20, cyc);
    checks++; if (!done || value !== 64'h00000000FFFFFFFE)
      begin failures++; $display("FAIL signed32 got=%h exp=00000000fffffffe", value); end
    do_start(5'd0, 1'b1, 1'b1);
    wait_done(20, cyc);
    checks++; if (!done || value !== 64'hFFFFFFFFFFFFFFFE)
      begin failures++; $display("FAIL signed64 got=%h exp=fffffffffffffffe", value); end
  endtask

  task automatic test_overlong;
    int cyc;
    for (int i = 8; i < 14; i++) rom[i] = 8'h80;
    do_start(5'd8, 1'b0, 1'b0);
    wait_done(30, cyc);
    checks++; if (!done || cyc != 10) begin failures++; $display("FAIL overlong_lat got=%0d done=%b exp=10", cyc, done); end
    checks++; if (error !== 2'd2 || value !== 64'd0)
      begin failures++; $display("FAIL overlong_err got=%h/%h exp=2/0", error, value); end
  endtask

  task automatic test_final_byte;
    int cyc;
    for (int i = 0; i < 4; i++) begin rom[16+i] = 8'hFF; rom[24+i] = 8'hFF; end
    rom[20] = 8'h7F; rom[28] = 8'h1F;
    do_start(5'd16, 1'b1, 1'b0);
    wait_done(30, cyc);
    checks++; if (!done || value !== 64'h00000000FFFFFFFF || error !== 2'd0 || next_addr !== 5'd21)
      begin failures++; $display("FAIL final_ok got=%h/%h/%h exp=ffffffff/0/15", value, error, next_addr); end
    do_start(5'd24, 1'b0, 1'b0);
    wait_done(30, cyc);
    checks++; if (!done || error !== 2'd3 || value !== 64'd0)
      begin failures++; $display("FAIL final_bad got=%h/%h exp=3/0", error, value); end
  endtask

  task automatic test_mem_error;
    int cyc;
    rom[0] = 8'h80; rerr[1] = 1'b1;
    do_start(5'd0, 1'b0, 1'b0);
    wait_done(20, cyc);
    checks++; if (!done || cyc != 4) begin failures++; $display("FAIL memerr_lat got=%0d done=%b exp=4", cyc, done); end
    checks++; if (error !== 2'd1 || value !== 64'd0)
      begin failures++; $display("FAIL memerr_err got=%h/%h exp=1/0", error, value); end
    rerr[1] = 1'b0;
  endtask

  task automatic test_reset_abort;
    int cyc;
    int seen = 0;
    do_start(5'd3, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL abort_busy got=%b/%b exp=0/0", busy, done); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_nodone got=%0d exp=0", seen); end
    do_start(5'd3, 1'b0, 1'b0);
    wait_done(20, cyc);
    checks++; if (!done || cyc != 6 || value !== 64'h98765)
      begin failures++; $display("FAIL abort_redo got=%h cyc=%0d exp=98765/6", value, cyc); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    rom[31] = 8'h81; rom[0] = 8'h01;
    do_start(5'd31, 1'b0, 1'b0);
    wait_done(20, cyc);
    checks++; if (!done || value !== 64'h81 || next_addr !== 5'd1)
      begin failures++; $display("FAIL wrap got=%h/%h exp=81/1", value, next_addr); end
    do_start(5'd0, 1'b0, 1'b0);
    start = 1'b1; addr_in = 5'd5;
    wait_done(20, cyc);
    start = 1'b0;
    checks++; if (!done || cyc != 2 || value !== 64'h1 || next_addr !== 5'd1)
      begin failures++; $display("FAIL b2b got=%h/%h cyc=%0d exp=1/1/2", value, next_addr, cyc); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_ignored got=%b exp=0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin rom[i] = 8'h00; rerr[i] = 1'b0; end
    reset = 1'b1; start = 1'b0; addr_in = '0; is_signed = 1'b0; is64 = 1'b0;
    @(negedge clk); @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_single;
    test_multi;
    test_signed;
    test_overlong;
    test_final_byte;
    test_mem_error;
    test_reset_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
